// File: rtl/alu_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_arbiter_if
//  Purpose  : One requester's channel into the shared-ALU arbiter: request
//             valid/ready with operation payload, and response valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic              src_sel;
    logic [DATA_W-1:0] shamt;
    logic              rsp_valid;
    logic              rsp_ready;

    // Requester side: issues operations and consumes results
    modport master (
        output valid, opcode, a, b, imm, src_sel, shamt, rsp_ready,
        input  ready, rsp_valid
    );

    // Arbiter side: accepts operations and returns results
    modport slave (
        input  valid, opcode, a, b, imm, src_sel, shamt, rsp_ready,
        output ready, rsp_valid
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_arbiter
//  Purpose  : Round-robin sharing of one 32-bit ALU between two requesters.
//             The granted operation is latched and drives the ALU from
//             registers; the result and flags are captured and returned to
//             the owner. MUL is held in EXEC for MUL_LAT cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  wire logic                clk,
    input  wire logic                rst,
    alu_issue_arbiter_if.slave       req0,
    alu_issue_arbiter_if.slave       req1,
    output logic [2*DATA_W-1:0]      rsp_data_o,
    output logic                     rsp_z_o,
    output logic                     rsp_carry_o,
    output logic                     busy_o,
    output logic [3:0]               alu_opcode_o,
    output logic [DATA_W-1:0]        alu_a_o,
    output logic [DATA_W-1:0]        alu_b_o,
    output logic [DATA_W-1:0]        alu_imm_o,
    output logic [DATA_W-1:0]        alu_shamt_o,
    output logic                     alu_src_sel_o,
    input  wire logic [2*DATA_W-1:0] alu_data_out_i,
    input  wire logic                alu_z_i,
    input  wire logic                alu_carry_i
);
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam int         CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [2*DATA_W-1:0] rsp_data_q;
    logic              rsp_z_q;
    logic              rsp_carry_q;
    logic [3:0]        alu_opcode_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [DATA_W-1:0] alu_imm_q;
    logic [DATA_W-1:0] alu_shamt_q;
    logic              alu_src_sel_q;

    // Grant: on contention the requester that did not win last time goes;
    // otherwise whichever one is valid. w_grant is only meaningful with w_any.
    logic w_any;
    logic w_grant;
    logic w_accept;
    logic w_rsp_taken;

    assign w_any       = req0.valid | req1.valid;
    assign w_grant     = (req0.valid & req1.valid) ? ~last_grant_q : req1.valid;
    assign w_accept    = (state_q == S_IDLE) & ~rst & w_any;
    assign req0.ready  = w_accept & ~w_grant;
    assign req1.ready  = w_accept &  w_grant;
    assign w_rsp_taken = owner_q ? req1.rsp_ready : req0.rsp_ready;

    // Payload of the granted requester
    logic [3:0]        w_opcode;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_shamt;
    logic              w_src_sel;

    assign w_opcode  = w_grant ? req1.opcode  : req0.opcode;
    assign w_a       = w_grant ? req1.a       : req0.a;
    assign w_b       = w_grant ? req1.b       : req0.b;
    assign w_imm     = w_grant ? req1.imm     : req0.imm;
    assign w_shamt   = w_grant ? req1.shamt   : req0.shamt;
    assign w_src_sel = w_grant ? req1.src_sel : req0.src_sel;

    // Issue FSM: latch on accept, hold ALU inputs through EXEC, capture result, return it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp_data_q    <= '0;
            rsp_z_q       <= 1'b0;
            rsp_carry_q   <= 1'b0;
            alu_opcode_q  <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_imm_q     <= '0;
            alu_shamt_q   <= '0;
            alu_src_sel_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_opcode_q  <= w_opcode;
                        alu_a_q       <= w_a;
                        alu_b_q       <= w_b;
                        alu_imm_q     <= w_imm;
                        alu_shamt_q   <= w_shamt;
                        alu_src_sel_q <= w_src_sel;
                        owner_q       <= w_grant;
                        last_grant_q  <= w_grant;
                        cnt_q         <= (w_opcode == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
                        busy_q        <= 1'b1;
                        state_q       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rsp_data_q   <= alu_data_out_i;
                        rsp_z_q      <= alu_z_i;
                        rsp_carry_q  <= alu_carry_i;
                        rsp0_valid_q <= ~owner_q;
                        rsp1_valid_q <=  owner_q;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_taken) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req0.rsp_valid = rsp0_valid_q;
    assign req1.rsp_valid = rsp1_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_z_o        = rsp_z_q;
    assign rsp_carry_o    = rsp_carry_q;
    assign busy_o         = busy_q;
    assign alu_opcode_o   = alu_opcode_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_imm_o      = alu_imm_q;
    assign alu_shamt_o    = alu_shamt_q;
    assign alu_src_sel_o  = alu_src_sel_q;
endmodule
`default_nettype wire
